consmax_lane_array: RTL and testbench
=====================================

Name: consmax_lane_array

Overview:
Multi-lane, parametrised successor to the single-lane consmax softmax unit. It maps NUM_LANE signed integer logits per beat to exp-domain values through one shared, software-loaded LUT. Each lane applies a configurable arithmetic right shift, then saturates to the LUT index range. The block adds ready/valid backpressure, row-end tagging, pipeline-safe LUT reloading and a saturation counter; it sits between the attention score stage and the normaliser.

Parameters:
NUM_LANE, 4, lanes processed per beat
IDATA_BIT, 16, signed input width per lane
CDATA_BIT, 8, width of the shift config
LUT_ADDR, 9, LUT index width; LUT depth is 2**LUT_ADDR
LUT_DATA, 16, LUT entry and output width per lane (bf16 exp value)
SAT_CNT_BIT, 16, saturation counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cfg_consmax_shift  in  CDATA_BIT  unsigned arithmetic right-shift amount, sampled at stage 1
lut_wen  in  1  LUT write request
lut_waddr  in  LUT_ADDR  LUT write address
lut_wdata  in  LUT_DATA  LUT write data
lut_wready  out  1  high when a LUT write is accepted this cycle
idata  in  NUM_LANE*IDATA_BIT  packed logits; lane i at bits [i*IDATA_BIT +: IDATA_BIT]
idata_valid  in  1  input beat valid
idata_last  in  1  beat is last of a row
idata_ready  out  1  input beat accepted when idata_valid && idata_ready
odata  out  NUM_LANE*LUT_DATA  packed LUT results, same lane order as idata
odata_valid  out  1  output beat valid
odata_last  out  1  row-end tag aligned with odata
odata_ready  in  1  downstream accept
sat_cnt  out  SAT_CNT_BIT  count of saturated lane samples, sticky at max

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst. There is no other reset.
- Reset values: odata=0, odata_valid=0, odata_last=0, sat_cnt=0, internal stage valids=0. LUT contents are not reset (undefined until written).
- LUT: register array of 2**LUT_ADDR x LUT_DATA with one write port and NUM_LANE combinational read ports.
- Pipeline, stage S1:
  - per lane: sh = idata_i >>> cfg_consmax_shift, signed arithmetic shift.
  - Shift amounts >= IDATA_BIT yield all sign bits (0 or -1).
  - sat = clamp(sh, -2**(LUT_ADDR-1), 2**(LUT_ADDR-1)-1).
  - addr = sat + 2**(LUT_ADDR-1), offset binary.
  - S1 registers addr per lane, a per-lane saturated flag, valid and last.
- Pipeline, stage S2: registers odata_i = LUT[addr_i], valid and last. Latency is 2 cycles from accept to odata_valid with no stall.
- Flow control:
  - en2 = !s2_valid || odata_ready.
  - en1 = !s1_valid || en2.
  - idata_ready = en1 && !lut_wen.
  - Full throughput: one beat per cycle when odata_ready is held high.
  - While odata_valid && !odata_ready, odata, odata_last and odata_valid hold stable.
  - A bubble in S1 advances into S2 as valid=0.
- LUT write:
  - lut_wready = lut_wen && !s1_valid && !s2_valid.
  - The write occurs on that edge.
  - While lut_wen is high, no new input is accepted, so the pipeline drains and the write then proceeds.
  - No read/write hazard exists.
- sat_cnt:
  - on each S1 accept, add the number of lanes whose sh was clamped (0..NUM_LANE).
  - Saturates at 2**SAT_CNT_BIT-1, no wrap.
  - Cleared only by rst.
- Reset mid-operation: in-flight beats are dropped; odata_valid=0 on the following cycle. The LUT keeps its contents.
- cfg_consmax_shift changes take effect on the next accepted beat only. Beats already in flight are unaffected.

Test Plan:
- LUT load: write LUT[a]=a ^ 16'hA5A5 for a=0..511 with the pipeline empty. Expect lut_wready=1 on every write cycle and no idata_ready while lut_wen=1.
- Mapping, NUM_LANE=4, shift=4: lanes {16'h0100, 16'h0000, 16'hFFF0, 16'h0010} give addr {272, 256, 255, 257}. odata equals the matching LUT values 2 cycles after accept; sat_cnt stays 0.
- Saturation, shift=0: lanes {16'h7FFF, 16'h8000, 16'h00FF, 16'hFF00} give addr {511, 0, 511, 0}. sat_cnt=2 (the 0x00FF and 0xFF00 lanes are in range and not clamped).
- Large shift=20: lane -1 gives addr 255; lane 16'h7FFF gives addr 256.
- Backpressure: stream 8 beats with idata_last on beat 8 and odata_ready toggling 1,0,0,1. Expect no beat lost or duplicated, odata held stable while stalled, and odata_last on the 8th output only.
- Reload and reset: assert lut_wen with 2 beats in flight and odata_ready=1. lut_wready rises exactly 2 cycles later. Then assert rst for 1 cycle mid-stream; odata_valid=0 and sat_cnt=0 next cycle, and the LUT is still intact on the next lookup.

Source files
------------

// File: rtl/consmax_lane_array.sv
// consmax_lane_array: NUM_LANE-wide logit -> exp-domain lookup.
// Each lane shifts its signed logit right, clamps it to the LUT index range
// and reads one shared, software-loaded LUT. The two-stage pipeline has
// ready/valid flow control, row-end tagging, a LUT write port that only
// fires once the pipeline is empty, and a sticky saturation counter.
module consmax_lane_array #(
  parameter int NUM_LANE    = 4,
  parameter int IDATA_BIT   = 16,
  parameter int CDATA_BIT   = 8,
  parameter int LUT_ADDR    = 9,
  parameter int LUT_DATA    = 16,
  parameter int SAT_CNT_BIT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CDATA_BIT-1:0]          cfg_consmax_shift,
  input  logic                          lut_wen,
  input  logic [LUT_ADDR-1:0]           lut_waddr,
  input  logic [LUT_DATA-1:0]           lut_wdata,
  output logic                          lut_wready,
  input  logic [NUM_LANE*IDATA_BIT-1:0] idata,
  input  logic                          idata_valid,
  input  logic                          idata_last,
  output logic                          idata_ready,
  output logic [NUM_LANE*LUT_DATA-1:0]  odata,
  output logic                          odata_valid,
  output logic                          odata_last,
  input  logic                          odata_ready,
  output logic [SAT_CNT_BIT-1:0]        sat_cnt
);

  localparam int LUT_DEPTH = 2 ** LUT_ADDR;
  localparam int HALF      = 2 ** (LUT_ADDR - 1);
  localparam int CNT_W     = $clog2(NUM_LANE + 1);
  localparam logic signed [IDATA_BIT-1:0] SAT_MAX   = IDATA_BIT'(HALF - 1);
  localparam logic signed [IDATA_BIT-1:0] SAT_MIN   = IDATA_BIT'(-HALF);
  localparam logic [CDATA_BIT-1:0]        SHIFT_LIM = CDATA_BIT'(IDATA_BIT);

  logic [LUT_DATA-1:0] lut_q [LUT_DEPTH];

  logic                 s1_valid_q, s1_last_q;
  logic [LUT_ADDR-1:0]  s1_addr_q [NUM_LANE];
  logic [LUT_ADDR-1:0]  s1_addr_d [NUM_LANE];
  logic                 s2_valid_q, s2_last_q;
  logic [NUM_LANE*LUT_DATA-1:0] odata_q, odata_d;
  logic [SAT_CNT_BIT-1:0] sat_cnt_q, sat_cnt_d;

  logic signed [IDATA_BIT-1:0] lane_in [NUM_LANE];
  logic signed [IDATA_BIT-1:0] lane_sh [NUM_LANE];
  logic [NUM_LANE-1:0]         clamp_d;
  logic [CNT_W-1:0]            n_clamp;
  logic [SAT_CNT_BIT:0]        sat_sum;

  logic en1, en2, accept;

  // Handshake: a stage advances when it is empty or its successor advances.
  // New beats are held off while a LUT write is pending so the pipe drains.
  assign en2         = !s2_valid_q || odata_ready;
  assign en1         = !s1_valid_q || en2;
  assign idata_ready = en1 && !lut_wen;
  assign accept      = idata_valid && idata_ready;
  assign lut_wready  = lut_wen && !s1_valid_q && !s2_valid_q;

  // Per-lane shift, clamp to the LUT index range and offset-binary address.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    n_clamp = '0;
    clamp_d = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      lane_in[i] = idata[i*IDATA_BIT +: IDATA_BIT];
      if (cfg_consmax_shift >= SHIFT_LIM)
        lane_sh[i] = {IDATA_BIT{lane_in[i][IDATA_BIT-1]}};
      else
        lane_sh[i] = lane_in[i] >>> cfg_consmax_shift;
      s1_addr_d[i] = {~lane_sh[i][LUT_ADDR-1], lane_sh[i][LUT_ADDR-2:0]};
      if (lane_sh[i] > SAT_MAX) begin
        s1_addr_d[i] = '1;
        clamp_d[i]   = 1'b1;
      end else if (lane_sh[i] < SAT_MIN) begin
        s1_addr_d[i] = '0;
        clamp_d[i]   = 1'b1;
      end
      n_clamp = n_clamp + CNT_W'(clamp_d[i]);
    end
  end

  // Saturation counter increment, sticky at all-ones.
  always_comb begin
    sat_sum   = {1'b0, sat_cnt_q} + (SAT_CNT_BIT + 1)'(n_clamp);
    sat_cnt_d = sat_cnt_q;
    if (accept)
      sat_cnt_d = sat_sum[SAT_CNT_BIT] ? '1 : sat_sum[SAT_CNT_BIT-1:0];
  end

  // Combinational LUT read, one port per lane, from the S1 addresses.
  always_comb begin
    odata_d = '0;
    for (int i = 0; i < NUM_LANE; i++)
      odata_d[i*LUT_DATA +: LUT_DATA] = lut_q[s1_addr_q[i]];
  end

  // Stage 1 control: valid/last; an idle cycle loads a bubble.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
      if (en1) begin
        s1_valid_q <= accept;
        s1_last_q  <= accept && idata_last;
      end
    end
  end

  // Stage 1 datapath: lane addresses, loaded only on an accepted beat.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_LANE; i++)
        s1_addr_q[i] <= s1_addr_d[i];
    end
  end

  // Stage 2: LUT results; held stable while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      odata_q    <= '0;
    end else if (en2) begin
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      if (s1_valid_q)
        odata_q <= odata_d;
    end
  end

  // LUT write port; only fires with the pipeline empty.
  always_ff @(posedge clk) begin
    // NOTE: the LUT array has no reset; software loads it, and it must
    // survive rst so a pipeline flush does not lose the table.
    if (lut_wready)
      lut_q[lut_waddr] <= lut_wdata;
  end

  assign odata       = odata_q;
  assign odata_valid = s2_valid_q;
  assign odata_last  = s2_last_q;
  assign sat_cnt     = sat_cnt_q;

endmodule

// File: tb/tb_consmax_lane_array.sv
// Self-checking bench for consmax_lane_array: a scoreboard queue receives the
// expected output beat at each accepted input and a monitor compares on every
// output handshake.
module tb_consmax_lane_array;

  localparam int NL = 4;
  localparam int IW = 16;
  localparam int AW = 9;
  localparam int DW = 16;

  typedef struct packed {
    logic [NL*DW-1:0] data;
    logic             last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        cfg_consmax_shift;
  logic              lut_wen;
  logic [AW-1:0]     lut_waddr;
  logic [DW-1:0]     lut_wdata;
  logic              lut_wready;
  logic [NL*IW-1:0]  idata;
  logic              idata_valid, idata_last, idata_ready;
  logic [NL*DW-1:0]  odata;
  logic              odata_valid, odata_last;
  logic              odata_ready = 1'b1;
  logic [15:0]       sat_cnt;

  consmax_lane_array dut (
    .clk(clk), .rst(rst), .cfg_consmax_shift(cfg_consmax_shift),
    .lut_wen(lut_wen), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .lut_wready(lut_wready), .idata(idata), .idata_valid(idata_valid),
    .idata_last(idata_last), .idata_ready(idata_ready), .odata(odata),
    .odata_valid(odata_valid), .odata_last(odata_last),
    .odata_ready(odata_ready), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  beat_t       sb[$];
  logic [DW-1:0] lut_model [2**AW];
  int          sat_model = 0;
  bit          bp_mode = 1'b0;
  int          bp_idx = 0;
  logic [3:0]  bp_pat = 4'b1001;  // ready sequence 1,0,0,1 (bit 0 first)

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: shift, clamp, offset; reports whether the lane was clamped.
  function automatic int ref_addr(input logic [IW-1:0] x, input int sh, output bit clamped);
    int v;
    v = int'($signed(x));
    if (sh >= IW) v = (v < 0) ? -1 : 0;
    else          v = v >>> sh;
    clamped = (v > 255) || (v < -256);
    if (v > 255)  v = 255;
    if (v < -256) v = -256;
    return v + 256;
  endfunction

  // Downstream ready pattern generator.
  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      odata_ready = bp_pat[bp_idx];
      bp_idx = (bp_idx + 1) % 4;
    end else begin
      odata_ready = 1'b1;
    end
  end

  // Output monitor: scoreboard compare on handshake, stability while stalled.
  logic             prev_stall = 1'b0;
  logic [NL*DW-1:0] prev_data;
  logic             prev_last;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(odata_valid), 64'd1);
        check("hold_data", odata, prev_data);
        check("hold_last", 64'(odata_last), 64'(prev_last));
      end
      if (odata_valid && odata_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 64'd1, 64'd0);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("odata", odata, e.data);
          check("odata_last", 64'(odata_last), 64'(e.last));
        end
      end
      prev_stall = odata_valid && !odata_ready;
      prev_data  = odata;
      prev_last  = odata_last;
    end
  end

  // Drive one beat (called just after a rising edge); returns just after the
  // edge that accepted it, with idata_valid still high.
  task automatic send_beat(input logic [NL*IW-1:0] d, input logic last);
    beat_t e;
    bit    c;
    bit    done = 1'b0;
    idata       = d;
    idata_last  = last;
    idata_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (idata_ready) begin
        e.last = last;
        for (int i = 0; i < NL; i++) begin
          e.data[i*DW +: DW] = lut_model[ref_addr(d[i*IW +: IW], int'(cfg_consmax_shift), c)];
          sat_model += int'(c);
        end
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    idata_valid = 1'b0;
    idata_last  = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    check("drain_left", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NL*IW-1:0] d;
    rst = 1'b1; lut_wen = 1'b0; lut_waddr = '0; lut_wdata = '0;
    idata = '0; idata_valid = 1'b0; idata_last = 1'b0; cfg_consmax_shift = 8'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(odata_valid), 64'd0);
    check("rst_last", 64'(odata_last), 64'd0);
    check("rst_odata", odata, 64'd0);
    check("rst_sat", 64'(sat_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LUT load with the pipeline empty
    for (int a = 0; a < 512; a++) begin
      lut_wen   = 1'b1;
      lut_waddr = AW'(a);
      lut_wdata = DW'(a) ^ 16'hA5A5;
      lut_model[a] = DW'(a) ^ 16'hA5A5;
      @(negedge clk);
      check("load_wready", 64'(lut_wready), 64'd1);
      check("load_iready", 64'(idata_ready), 64'd0);
      @(posedge clk); #1;
    end
    lut_wen = 1'b0;

    // Mapping, shift=4, with 2-cycle latency check
    cfg_consmax_shift = 8'd4;
    send_beat({16'h0010, 16'hFFF0, 16'h0000, 16'h0100}, 1'b0);
    idle();
    @(negedge clk);
    check("lat_c1", 64'(odata_valid), 64'd0);
    @(negedge clk);
    check("lat_c2", 64'(odata_valid), 64'd1);
    check("map_lane0", 64'(odata[15:0]), 64'(16'd272 ^ 16'hA5A5));
    drain();
    check("map_sat", 64'(sat_cnt), 64'd0);

    // Saturation, shift=0
    cfg_consmax_shift = 8'd0;
    send_beat({16'hFF00, 16'h00FF, 16'h8000, 16'h7FFF}, 1'b0);
    idle();
    drain();
    check("sat_cnt2", 64'(sat_cnt), 64'd2);
    check("sat_model", 64'(sat_cnt), 64'(sat_model));

    // Shift beyond the input width
    cfg_consmax_shift = 8'd20;
    send_beat({16'h8000, 16'h0000, 16'h7FFF, 16'hFFFF}, 1'b0);
    idle();
    @(negedge clk); @(negedge clk);
    check("big_lane0", 64'(odata[15:0]), 64'(16'd255 ^ 16'hA5A5));
    check("big_lane1", 64'(odata[31:16]), 64'(16'd256 ^ 16'hA5A5));
    drain();

    // Backpressure stream of 8 beats, last on beat 8
    cfg_consmax_shift = 8'd3;
    bp_mode = 1'b1;
    for (int b = 0; b < 8; b++) begin
      d = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      send_beat(d, b == 7);
    end
    idle();
    drain();
    bp_mode = 1'b0;
    check("bp_sat", 64'(sat_cnt), 64'(sat_model));

    // Reload with two beats in flight
    cfg_consmax_shift = 8'd0;
    send_beat({16'h0000, 16'h0001, 16'hFFFF, 16'h0000}, 1'b0);
    send_beat({16'h0000, 16'h0000, 16'h0000, 16'h0000}, 1'b1);
    idle();
    lut_wen = 1'b1; lut_waddr = 9'd256; lut_wdata = 16'h1234;
    @(negedge clk);
    check("wr_c0", 64'(lut_wready), 64'd0);
    check("wr_iready", 64'(idata_ready), 64'd0);
    @(negedge clk);
    check("wr_c1", 64'(lut_wready), 64'd0);
    @(negedge clk);
    check("wr_c2", 64'(lut_wready), 64'd1);
    lut_model[256] = 16'h1234;
    @(posedge clk); #1;
    lut_wen = 1'b0;
    drain();

    // Reset mid-stream
    send_beat({16'h0000, 16'h0000, 16'h0000, 16'h7FFF}, 1'b0);
    send_beat({16'h0003, 16'h0002, 16'h0001, 16'h0000}, 1'b0);
    send_beat({16'h0010, 16'h0020, 16'h0030, 16'h0040}, 1'b0);
    rst = 1'b1;
    idle();
    sb.delete();
    sat_model = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(odata_valid), 64'd0);
    check("mid_rst_sat", 64'(sat_cnt), 64'd0);
    @(posedge clk); #1;

    // LUT kept across reset, including the reloaded entry
    send_beat({16'h0000, 16'hFFFF, 16'h0001, 16'h0000}, 1'b1);
    idle();
    @(negedge clk); @(negedge clk);
    check("keep_lane0", 64'(odata[15:0]), 64'h1234);
    drain();
    check("end_sat", 64'(sat_cnt), 64'(sat_model));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
